// File: rtl/img2col_sched_pkg.sv
// Shared definitions for the img2col scheduler: kernel size and FSM state encoding.
package img2col_sched_pkg;

`ifndef S2P_SIZE
`define S2P_SIZE 3
`endif

    // Kernel edge length K; a window is K*K elements.
    localparam int unsigned K_SIZE = `S2P_SIZE;
    // Width of the kx/ky kernel counters (at least one bit).
    localparam int unsigned K_W    = (K_SIZE > 1) ? $clog2(K_SIZE) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

endpackage

// File: rtl/img2col_sched_if.sv
// Command, memory-read and data_process handshake signals of the img2col scheduler.
interface img2col_sched_if #(
    parameter int unsigned DIM_W  = 8,
    parameter int unsigned ADDR_W = 16
) ();
    logic [DIM_W-1:0]   cfg_img_h;
    logic [DIM_W-1:0]   cfg_img_w;
    logic [DIM_W-1:0]   cfg_pad;
    logic [DIM_W-1:0]   cfg_stride;
    logic               cmd_start;
    logic               busy;
    logic               done;
    logic               err;
    logic               t_rd_en;
    logic [ADDR_W-1:0]  t_addr;
    logic               w_rd_en;
    logic [ADDR_W-1:0]  w_addr;
    logic               dp_start;
    logic               dp_t_pad;
    logic               dp_w_pad;
    logic               flag_buffer;
    logic               dn_ready;
    logic [2*DIM_W-1:0] win_cnt;

    // Host / environment side: issues commands, returns window-complete and ready.
    modport master (
        output cfg_img_h, cfg_img_w, cfg_pad, cfg_stride, cmd_start, flag_buffer, dn_ready,
        input  busy, done, err, t_rd_en, t_addr, w_rd_en, w_addr,
               dp_start, dp_t_pad, dp_w_pad, win_cnt
    );

    // Scheduler side.
    modport slave (
        input  cfg_img_h, cfg_img_w, cfg_pad, cfg_stride, cmd_start, flag_buffer, dn_ready,
        output busy, done, err, t_rd_en, t_addr, w_rd_en, w_addr,
               dp_start, dp_t_pad, dp_w_pad, win_cnt
    );
endinterface

// File: rtl/img2col_win_cnt.sv
// Nested window (oy/ox) and kernel (ky/kx) counters with tensor bounds check and addresses.
// Window origin is tracked in padded-image coordinates (origin = o*S), which avoids a divider.
module img2col_win_cnt
    import img2col_sched_pkg::*;
#(
    parameter int unsigned DIM_W  = 8,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr_i,
    input  logic              adv_i,
    input  logic [DIM_W-1:0]  h_i,
    input  logic [DIM_W-1:0]  w_i,
    input  logic [DIM_W-1:0]  pad_i,
    input  logic [DIM_W-1:0]  stride_i,
    output logic              win_first_c_o,
    output logic              win_end_c_o,
    output logic              win_last_c_o,
    output logic              in_bnd_c_o,
    output logic [ADDR_W-1:0] t_addr_c_o,
    output logic [ADDR_W-1:0] w_addr_c_o
);
    localparam int unsigned   EW     = DIM_W + 3;
    localparam int unsigned   PW     = EW + DIM_W;
    localparam logic [K_W-1:0] K_LAST = K_W'(K_SIZE - 1);

    logic [K_W-1:0] kx_q, kx_d, ky_q, ky_d;
    logic [EW-1:0]  rx_q, rx_d, ry_q, ry_d;
    logic [EW-1:0]  pad_c, step_c, ext_h_c, ext_w_c;
    logic [EW-1:0]  sum_y_c, sum_x_c, iy_c, ix_c;
    logic           kx_end_c, ky_end_c, col_last_c, row_last_c;
    logic [PW-1:0]  lin_c;

    // Position of the current element and window inside the padded image.
    always_comb begin
        pad_c      = EW'(pad_i);
        step_c     = EW'(stride_i);
        ext_h_c    = EW'(h_i) + (pad_c << 1);
        ext_w_c    = EW'(w_i) + (pad_c << 1);
        sum_y_c    = ry_q + EW'(ky_q);
        sum_x_c    = rx_q + EW'(kx_q);
        iy_c       = sum_y_c - pad_c;
        ix_c       = sum_x_c - pad_c;
        in_bnd_c_o = (sum_y_c >= pad_c) && (iy_c < EW'(h_i)) &&
                     (sum_x_c >= pad_c) && (ix_c < EW'(w_i));
        kx_end_c   = (kx_q == K_LAST);
        ky_end_c   = (ky_q == K_LAST);
        // The next window would no longer fit inside the padded extent.
        col_last_c = (rx_q + step_c + EW'(K_SIZE)) > ext_w_c;
        row_last_c = (ry_q + step_c + EW'(K_SIZE)) > ext_h_c;
        win_first_c_o = (kx_q == '0) && (ky_q == '0);
        win_end_c_o   = kx_end_c && ky_end_c;
        win_last_c_o  = col_last_c && row_last_c;
        lin_c         = PW'(iy_c) * PW'(w_i) + PW'(ix_c);
        t_addr_c_o    = ADDR_W'(lin_c);
        w_addr_c_o    = ADDR_W'(ky_q) * ADDR_W'(K_SIZE) + ADDR_W'(kx_q);
    end

    // Row-major kernel walk, then ox advance with wrap into the next oy.
    always_comb begin
        kx_d = kx_q;
        ky_d = ky_q;
        rx_d = rx_q;
        ry_d = ry_q;
        if (clr_i) begin
            kx_d = '0;
            ky_d = '0;
            rx_d = '0;
            ry_d = '0;
        end else if (adv_i) begin
            if (!kx_end_c) begin
                kx_d = kx_q + K_W'(1);
            end else begin
                kx_d = '0;
                if (!ky_end_c) begin
                    ky_d = ky_q + K_W'(1);
                end else begin
                    ky_d = '0;
                    if (col_last_c) begin
                        rx_d = '0;
                        ry_d = ry_q + step_c;
                    end else begin
                        rx_d = rx_q + step_c;
                    end
                end
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            kx_q <= '0;
            ky_q <= '0;
            rx_q <= '0;
            ry_q <= '0;
        end else begin
            kx_q <= kx_d;
            ky_q <= ky_d;
            rx_q <= rx_d;
            ry_q <= ry_d;
        end
    end

endmodule

// File: rtl/img2col_sched.sv
// img2col scheduler: streams K*K tensor/weight reads per output window into data_process.
// Outputs are registered from next-state, so they are valid in the cycle the FSM is in STREAM.
module img2col_sched
    import img2col_sched_pkg::*;
#(
    parameter int unsigned DIM_W  = 8,
    parameter int unsigned ADDR_W = 16
) (
    input  logic           clk,
    input  logic           rstn,
    img2col_sched_if.slave bus
);
    localparam int unsigned CW = 2 * DIM_W;
    localparam int unsigned XW = DIM_W + 2;

    state_e            state_q, state_d;
    logic [DIM_W-1:0]  h_q, h_d, w_q, w_d, pad_q, pad_d, stride_q, stride_d;
    logic [CW-1:0]     win_cnt_q, win_cnt_d, iss_cnt_q, iss_cnt_d;
    logic              all_iss_q, all_iss_d;

    logic              busy_q, done_q, err_q, dp_start_q;
    logic              t_rd_en_q, w_rd_en_q, dp_t_pad_q, dp_w_pad_q;
    logic [ADDR_W-1:0] t_addr_q, w_addr_q;

    logic              issue_c, clr_c, cfg_bad_c, flag_ok_c;
    logic              win_first_c, win_end_c, win_last_c, in_bnd_c;
    logic [ADDR_W-1:0] t_addr_c, w_addr_c;

    img2col_win_cnt #(
        .DIM_W  (DIM_W),
        .ADDR_W (ADDR_W)
    ) u_win_cnt (
        .clk           (clk),
        .rstn          (rstn),
        .clr_i         (clr_c),
        .adv_i         (issue_c),
        .h_i           (h_q),
        .w_i           (w_q),
        .pad_i         (pad_q),
        .stride_i      (stride_q),
        .win_first_c_o (win_first_c),
        .win_end_c_o   (win_end_c),
        .win_last_c_o  (win_last_c),
        .in_bnd_c_o    (in_bnd_c),
        .t_addr_c_o    (t_addr_c),
        .w_addr_c_o    (w_addr_c)
    );

    // Configuration that yields no window at all.
    always_comb begin
        cfg_bad_c = ((XW'(h_q) + (XW'(pad_q) << 1)) < XW'(K_SIZE)) ||
                    ((XW'(w_q) + (XW'(pad_q) << 1)) < XW'(K_SIZE)) ||
                    (stride_q == '0);
        flag_ok_c = bus.flag_buffer && (state_q inside {ST_WAIT, ST_STREAM, ST_DRAIN});
    end

    // Next-state, config latch, window bookkeeping and element issue.
    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        w_d       = w_q;
        pad_d     = pad_q;
        stride_d  = stride_q;
        win_cnt_d = win_cnt_q;
        iss_cnt_d = iss_cnt_q;
        all_iss_d = all_iss_q;
        issue_c   = 1'b0;
        clr_c     = 1'b0;
        if (flag_ok_c) begin
            win_cnt_d = win_cnt_q + CW'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_start) begin
                    state_d   = ST_CHECK;
                    h_d       = bus.cfg_img_h;
                    w_d       = bus.cfg_img_w;
                    pad_d     = bus.cfg_pad;
                    stride_d  = bus.cfg_stride;
                    win_cnt_d = '0;
                    iss_cnt_d = '0;
                    all_iss_d = 1'b0;
                    clr_c     = 1'b1;
                end
            end
            ST_CHECK: begin
                state_d = cfg_bad_c ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.dn_ready) begin
                    state_d = ST_STREAM;
                    issue_c = 1'b1;
                end
            end
            ST_STREAM: begin
                // At a window boundary the counters already point at the next window.
                if (!win_first_c) begin
                    issue_c = 1'b1;
                end else if (all_iss_q) begin
                    state_d = ST_DRAIN;
                end else if (bus.dn_ready) begin
                    issue_c = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (win_cnt_d == iss_cnt_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (issue_c && win_end_c) begin
            iss_cnt_d = iss_cnt_q + CW'(1);
            if (win_last_c) begin
                all_iss_d = 1'b1;
            end
        end
    end

    // State, latched configuration and window counters.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            h_q       <= '0;
            w_q       <= '0;
            pad_q     <= '0;
            stride_q  <= '0;
            win_cnt_q <= '0;
            iss_cnt_q <= '0;
            all_iss_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            w_q       <= w_d;
            pad_q     <= pad_d;
            stride_q  <= stride_d;
            win_cnt_q <= win_cnt_d;
            iss_cnt_q <= iss_cnt_d;
            all_iss_q <= all_iss_d;
        end
    end

    // Registered outputs; idle cycles shift zeros into the data_process buffer.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            dp_start_q <= 1'b0;
            t_rd_en_q  <= 1'b0;
            t_addr_q   <= '0;
            dp_t_pad_q <= 1'b1;
            w_rd_en_q  <= 1'b0;
            w_addr_q   <= '0;
            dp_w_pad_q <= 1'b1;
        end else begin
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_DONE);
            err_q      <= (state_d == ST_DONE) && cfg_bad_c;
            dp_start_q <= issue_c;
            t_rd_en_q  <= issue_c && in_bnd_c;
            t_addr_q   <= (issue_c && in_bnd_c) ? t_addr_c : '0;
            dp_t_pad_q <= !(issue_c && in_bnd_c);
            w_rd_en_q  <= issue_c;
            w_addr_q   <= issue_c ? w_addr_c : '0;
            dp_w_pad_q <= !issue_c;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.dp_start = dp_start_q;
    assign bus.t_rd_en  = t_rd_en_q;
    assign bus.t_addr   = t_addr_q;
    assign bus.dp_t_pad = dp_t_pad_q;
    assign bus.w_rd_en  = w_rd_en_q;
    assign bus.w_addr   = w_addr_q;
    assign bus.dp_w_pad = dp_w_pad_q;
    assign bus.win_cnt  = win_cnt_q;

endmodule

// File: tb/tb_img2col_sched.sv
// Scoreboard bench for img2col_sched: a reference window walk fills the expected queue,
// and every dp_start cycle pops and compares one element.
module tb_img2col_sched;
    import img2col_sched_pkg::*;

    localparam int unsigned TB_DW    = 8;
    localparam int unsigned TB_AW    = 16;
    localparam int          KK       = K_SIZE * K_SIZE;
    localparam int          FLAG_LAT = 2;
    localparam int          GAP      = 5;
    localparam int          BUDGET   = 3000;

    typedef struct packed {
        logic             t_en;
        logic [TB_AW-1:0] t_addr;
        logic [TB_AW-1:0] w_addr;
        logic             t_pad;
    } elem_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    img2col_sched_if #(.DIM_W(TB_DW), .ADDR_W(TB_AW)) bus ();

    img2col_sched #(.DIM_W(TB_DW), .ADDR_W(TB_AW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    elem_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int elem_n, win_seen, flag_cd, gap_left, gap_win, idle_run, ds_total, ds_runs;
    bit gap_pend, prev_ds;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference walk: floor-divided output grid, row-major kernel, signed bounds test.
    task automatic model(input int h, input int w, input int p, input int s, output int n);
        int oh, ow, iy, ix;
        elem_t e;
        n = 0;
        if (h + 2*p < K_SIZE || w + 2*p < K_SIZE || s == 0) return;
        oh = (h + 2*p - K_SIZE) / s + 1;
        ow = (w + 2*p - K_SIZE) / s + 1;
        n  = oh * ow;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int ky = 0; ky < K_SIZE; ky++)
                    for (int kx = 0; kx < K_SIZE; kx++) begin
                        iy = oy*s + ky - p;
                        ix = ox*s + kx - p;
                        e.w_addr = TB_AW'(ky*K_SIZE + kx);
                        if (iy >= 0 && iy < h && ix >= 0 && ix < w) begin
                            e.t_en = 1'b1; e.t_addr = TB_AW'(iy*w + ix); e.t_pad = 1'b0;
                        end else begin
                            e.t_en = 1'b0; e.t_addr = '0; e.t_pad = 1'b1;
                        end
                        exp_q.push_back(e);
                    end
    endtask

    // One clock: sample at negedge, check outputs, then drive flag_buffer/dn_ready.
    task automatic tick();
        elem_t e;
        @(negedge clk);
        if (!rstn) begin
            exp_q.delete();
            elem_n = 0; win_seen = 0; flag_cd = 0; gap_left = 0; gap_pend = 0;
            idle_run = 0; prev_ds = 0;
            bus.flag_buffer = 1'b0;
            bus.dn_ready    = 1'b1;
            return;
        end
        bus.flag_buffer = 1'b0;
        if (flag_cd > 0) begin
            flag_cd--;
            if (flag_cd == 0) bus.flag_buffer = 1'b1;
        end
        if (gap_left > 0) gap_left--;
        if (bus.dp_start) begin
            if (gap_pend) begin
                chk("gap_len", 32'(idle_run), 32'(GAP));
                gap_pend = 0;
            end
            if (!prev_ds) ds_runs++;
            ds_total++;
            idle_run = 0;
            if (exp_q.size() == 0) begin
                chk("unexpected_elem", 32'(bus.dp_start), 0);
            end else begin
                e = exp_q.pop_front();
                chk("t_rd_en",  32'(bus.t_rd_en),  32'(e.t_en));
                chk("t_addr",   32'(bus.t_addr),   32'(e.t_addr));
                chk("dp_t_pad", 32'(bus.dp_t_pad), 32'(e.t_pad));
                chk("w_rd_en",  32'(bus.w_rd_en),  1);
                chk("w_addr",   32'(bus.w_addr),   32'(e.w_addr));
                chk("dp_w_pad", 32'(bus.dp_w_pad), 0);
            end
            elem_n++;
            if (elem_n == KK) begin
                elem_n = 0;
                win_seen++;
                flag_cd = FLAG_LAT;
                if (win_seen == gap_win) begin
                    gap_left = GAP;
                    gap_pend = 1;
                end
            end
        end else begin
            idle_run++;
            chk("idle_t_rd_en",  32'(bus.t_rd_en),  0);
            chk("idle_w_rd_en",  32'(bus.w_rd_en),  0);
            chk("idle_dp_t_pad", 32'(bus.dp_t_pad), 1);
            chk("idle_dp_w_pad", 32'(bus.dp_w_pad), 1);
        end
        prev_ds = bus.dp_start;
        bus.dn_ready = (gap_left == 0);
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_busy"},     32'(bus.busy),     0);
        chk({pfx, "_done"},     32'(bus.done),     0);
        chk({pfx, "_err"},      32'(bus.err),      0);
        chk({pfx, "_t_rd_en"},  32'(bus.t_rd_en),  0);
        chk({pfx, "_w_rd_en"},  32'(bus.w_rd_en),  0);
        chk({pfx, "_dp_start"}, 32'(bus.dp_start), 0);
        chk({pfx, "_t_addr"},   32'(bus.t_addr),   0);
        chk({pfx, "_w_addr"},   32'(bus.w_addr),   0);
        chk({pfx, "_win_cnt"},  32'(bus.win_cnt),  0);
        chk({pfx, "_dp_t_pad"}, 32'(bus.dp_t_pad), 1);
        chk({pfx, "_dp_w_pad"}, 32'(bus.dp_w_pad), 1);
    endtask

    task automatic start_job(input int h, input int w, input int p, input int s, output int n);
        model(h, w, p, s, n);
        ds_total = 0; ds_runs = 0; win_seen = 0; elem_n = 0;
        bus.cfg_img_h  = TB_DW'(h);
        bus.cfg_img_w  = TB_DW'(w);
        bus.cfg_pad    = TB_DW'(p);
        bus.cfg_stride = TB_DW'(s);
        bus.cmd_start  = 1'b1;
        tick();
        bus.cmd_start  = 1'b0;
        bus.cfg_img_h  = '1;
        bus.cfg_img_w  = '1;
        bus.cfg_pad    = '1;
        bus.cfg_stride = '1;
        chk("start_busy",    32'(bus.busy),    1);
        chk("start_win_clr", 32'(bus.win_cnt), 0);
    endtask

    task automatic wait_done(input int n, input int exp_err);
        int t = 0;
        while (!bus.done && t < BUDGET) begin
            tick();
            t++;
        end
        if (!bus.done) begin
            chk("done_timeout", 32'(bus.done), 1);
        end else begin
            chk("done_err",     32'(bus.err),        32'(exp_err));
            chk("done_win_cnt", 32'(bus.win_cnt),    32'(n));
            chk("done_busy",    32'(bus.busy),       1);
            chk("sb_drained",   32'(exp_q.size()),   0);
            tick();
            chk("done_pulse",   32'(bus.done),       0);
            chk("idle_busy",    32'(bus.busy),       0);
            chk("win_cnt_hold", 32'(bus.win_cnt),    32'(n));
        end
    endtask

    initial begin
        int n, t;
        rstn = 1'b0;
        gap_win = 0;
        bus.cmd_start = 1'b0;
        bus.cfg_img_h = '0; bus.cfg_img_w = '0; bus.cfg_pad = '0; bus.cfg_stride = '0;
        bus.flag_buffer = 1'b0;
        bus.dn_ready = 1'b1;
        repeat (3) tick();
        chk_reset_vals("rst");
        rstn = 1'b1;
        tick();

        // 4x4, P=0, S=1: four windows, one contiguous stream; a busy cmd_start is ignored.
        start_job(4, 4, 0, 1, n);
        repeat (10) tick();
        bus.cfg_img_h = 8'd2; bus.cfg_img_w = 8'd2; bus.cfg_stride = 8'd1; bus.cfg_pad = 8'd0;
        bus.cmd_start = 1'b1;
        tick();
        bus.cmd_start = 1'b0;
        chk("busy_cmd_ignored", 32'(bus.busy), 1);
        wait_done(n, 0);
        chk("a_dp_start_cycles", 32'(ds_total), 32'(n * KK));
        chk("a_dp_start_runs",   32'(ds_runs),  1);

        // Padding 1: border elements become pad flags.
        start_job(4, 4, 1, 1, n);
        wait_done(n, 0);

        // Stride 2 with a 5-cycle consumer stall after window 1.
        gap_win = 2;
        start_job(5, 5, 0, 2, n);
        wait_done(n, 0);
        chk("gap_observed", 32'(gap_pend), 0);
        gap_win = 0;

        // Non-square image with padding and stride.
        start_job(6, 5, 1, 2, n);
        wait_done(n, 0);

        // Configurations with no valid window.
        start_job(2, 2, 0, 1, n);
        wait_done(n, 1);
        start_job(4, 4, 0, 0, n);
        wait_done(n, 1);

        // Reset in the middle of window 2, then a fresh run from window 0.
        start_job(4, 4, 1, 1, n);
        t = 0;
        while (!(win_seen == 2 && elem_n == 4) && t < BUDGET) begin
            tick();
            t++;
        end
        chk("reach_mid_win2", 32'(win_seen), 2);
        rstn = 1'b0;
        tick();
        chk_reset_vals("midrst");
        tick();
        chk("midrst_no_done", 32'(bus.done), 0);
        rstn = 1'b1;
        tick();
        start_job(4, 4, 1, 1, n);
        wait_done(n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
